// File: rtl/muxn_scan.sv
// Channel multiplexer with manual select and timed auto-scan over CH channels.
// All outputs come straight from flops; next values are decided by the state being entered.
module muxn_scan #(
    parameter int CH    = 4,
    parameter int DW    = 8,
    parameter int DWELL = 4,
    localparam int SELW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    input  logic [CH*DW-1:0]   in_bus,
    output logic [DW-1:0]      out,
    output logic [SELW-1:0]    ch,
    output logic [CH-1:0]      onehot,
    output logic               strobe,
    output logic               sel_err,
    output logic [1:0]         state_dbg
);
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [DW-1:0]   out_n;
    logic [SELW-1:0] ch_n;
    logic [CH-1:0]   onehot_n;
    logic            strobe_n;
    logic            sel_err_n;
    logic            sel_ok;
    logic [SELW-1:0] ch_adv;
    logic [DW-1:0]   chan [CH];

    for (genvar k = 0; k < CH; k++) begin : g_chan
        assign chan[k] = in_bus[k*DW +: DW];
    end

    function automatic logic [CH-1:0] decode(input logic [SELW-1:0] idx);
        for (int k = 0; k < CH; k++) decode[k] = (idx == SELW'(k));
    endfunction

    assign sel_ok    = (32'(sel) < CH);
    // Explicit wrap so non-power-of-2 channel counts never reach index CH.
    assign ch_adv    = (ch == SELW'(CH - 1)) ? '0 : ch + SELW'(1);
    assign state_dbg = state;

    always_comb begin
        state_n = IDLE;
        if (en) state_n = mode ? SCAN : MANUAL;
    end

    always_comb begin
        out_n     = out;
        ch_n      = ch;
        onehot_n  = '0;
        strobe_n  = 1'b0;
        sel_err_n = 1'b0;
        cnt_n     = '0;
        case (state_n)
            MANUAL: begin
                if (sel_ok) begin
                    ch_n     = sel;
                    out_n    = chan[sel];
                    onehot_n = decode(sel);
                    strobe_n = (sel != ch) || (state != MANUAL);
                end else begin
                    onehot_n  = onehot;
                    sel_err_n = 1'b1;
                end
            end
            SCAN: begin
                if (state != SCAN) begin
                    ch_n     = '0;
                    out_n    = chan[0];
                    onehot_n = decode('0);
                    strobe_n = 1'b1;
                end else if (cnt == CW'(DWELL - 1)) begin
                    ch_n     = ch_adv;
                    out_n    = chan[ch_adv];
                    onehot_n = decode(ch_adv);
                    strobe_n = 1'b1;
                end else begin
                    cnt_n    = cnt + CW'(1);
                    out_n    = chan[ch];
                    onehot_n = decode(ch);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            out     <= '0;
            ch      <= '0;
            onehot  <= '0;
            strobe  <= 1'b0;
            sel_err <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            out     <= out_n;
            ch      <= ch_n;
            onehot  <= onehot_n;
            strobe  <= strobe_n;
            sel_err <= sel_err_n;
        end
    end
endmodule
